// File: rtl/sram_arbiter_pkg.sv
// Shared definitions for the SRAM arbiter: FSM encoding, owner tags and the
// load/store opcodes that decode also keys on.
package sram_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ACK    = 2'd2
    } state_t;

    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

    localparam logic [5:0] OP_LW = 6'b100011;
    localparam logic [5:0] OP_LB = 6'b100000;
    localparam logic [5:0] OP_SW = 6'b101011;

endpackage

// File: rtl/sram_arbiter_if.sv
// Requester (IF/MEM) and SRAM pin bundle; master is the pipeline/SRAM side,
// slave is the arbiter.
interface sram_arbiter_if #(
    parameter int ADDR_W = 20
);
    logic              if_req;
    logic [31:0]       if_addr;
    logic              if_ack;
    logic [31:0]       if_rdata;

    logic              mem_req;
    logic              mem_we;
    logic              mem_byte;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ack;
    logic [31:0]       mem_rdata;

    logic [ADDR_W-1:0] sram_addr;
    logic [31:0]       sram_wdata;
    logic [31:0]       sram_rdata;
    logic              sram_ce_n;
    logic              sram_oe_n;
    logic              sram_we_n;

    logic              stall;

    modport master (
        output if_req, if_addr, mem_req, mem_we, mem_byte, mem_addr, mem_wdata, sram_rdata,
        input  if_ack, if_rdata, mem_ack, mem_rdata,
        input  sram_addr, sram_wdata, sram_ce_n, sram_oe_n, sram_we_n, stall
    );

    modport slave (
        input  if_req, if_addr, mem_req, mem_we, mem_byte, mem_addr, mem_wdata, sram_rdata,
        output if_ack, if_rdata, mem_ack, mem_rdata,
        output sram_addr, sram_wdata, sram_ce_n, sram_oe_n, sram_we_n, stall
    );

endinterface

// File: rtl/byte_lane_extract.sv
// Picks little-endian byte lane i_lane out of i_word and sign-extends it.
// Purely combinational, zero latency, no flow control.
module byte_lane_extract (
    input  logic [31:0] i_word,
    input  logic [1:0]  i_lane,
    output logic [31:0] o_data
);

    logic [7:0] w_byte;

    assign w_byte = i_word[{i_lane, 3'b000} +: 8];
    assign o_data = {{24{w_byte[7]}}, w_byte};

endmodule

// File: rtl/sram_arbiter.sv
// Shares one single-port SRAM between fetch and data; DATA wins ties. Ack arrives
// WAIT_CYCLES+1 cycles after the grant; the loser waits with req held, stall covers both.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 20,
    parameter int WAIT_CYCLES = 2
) (
    input  logic           clk,
    input  logic           rst,
    sram_arbiter_if.slave  bus
);

    state_t            r_state;
    state_t            w_next;
    logic              r_owner;
    logic              r_we;
    logic              r_byte;
    logic [1:0]        r_lane;
    logic [3:0]        r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_if_rdata;
    logic [31:0]       r_mem_rdata;

    logic              w_grant;
    logic              w_grant_data;
    logic              w_capture;
    logic              w_ce_n;
    logic              w_oe_n;
    logic              w_we_n;
    logic              w_if_ack;
    logic              w_mem_ack;
    logic [31:0]       w_lb_data;
    logic              w_unused_bits;

    byte_lane_extract u_lane (
        .i_word (bus.sram_rdata),
        .i_lane (r_lane),
        .o_data (w_lb_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_grant      = 1'b0;
        w_grant_data = 1'b0;
        w_capture    = 1'b0;
        w_ce_n       = 1'b1;
        w_oe_n       = 1'b1;
        w_we_n       = 1'b1;
        w_if_ack     = 1'b0;
        w_mem_ack    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.mem_req) begin
                    w_grant      = 1'b1;
                    w_grant_data = 1'b1;
                    w_next       = ST_ACCESS;
                end else if (bus.if_req) begin
                    w_grant = 1'b1;
                    w_next  = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                w_ce_n = 1'b0;
                w_oe_n = r_we;
                // Last write cycle releases WE so address/data are held past its rising edge.
                if (r_we) begin
                    w_we_n = ~((r_cnt != 4'd0) || (WAIT_CYCLES == 1));
                end
                if (r_cnt == 4'd0) begin
                    w_capture = ~r_we;
                    w_next    = ST_ACK;
                end
            end
            ST_ACK: begin
                w_if_ack  = (r_owner == OWN_INST);
                w_mem_ack = (r_owner == OWN_DATA);
                w_next    = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner     <= OWN_INST;
            r_we        <= 1'b0;
            r_byte      <= 1'b0;
            r_lane      <= 2'b00;
            r_cnt       <= 4'd0;
            r_addr      <= '0;
            r_wdata     <= 32'd0;
            r_if_rdata  <= 32'd0;
            r_mem_rdata <= 32'd0;
        end else begin
            if (w_grant) begin
                r_owner <= w_grant_data ? OWN_DATA : OWN_INST;
                r_addr  <= w_grant_data ? bus.mem_addr[ADDR_W+1:2] : bus.if_addr[ADDR_W+1:2];
                r_we    <= w_grant_data & bus.mem_we;
                r_byte  <= w_grant_data & bus.mem_byte;
                r_lane  <= w_grant_data ? bus.mem_addr[1:0] : 2'b00;
                r_wdata <= w_grant_data ? bus.mem_wdata : 32'd0;
                r_cnt   <= 4'(WAIT_CYCLES - 1);
            end else if (r_state == ST_ACCESS && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_capture) begin
                if (r_owner == OWN_INST) begin
                    r_if_rdata <= bus.sram_rdata;
                end else begin
                    r_mem_rdata <= r_byte ? w_lb_data : bus.sram_rdata;
                end
            end
        end
    end

    assign bus.sram_addr  = r_addr;
    assign bus.sram_wdata = r_wdata;
    assign bus.sram_ce_n  = w_ce_n;
    assign bus.sram_oe_n  = w_oe_n;
    assign bus.sram_we_n  = w_we_n;
    assign bus.if_ack     = w_if_ack;
    assign bus.mem_ack    = w_mem_ack;
    assign bus.if_rdata   = r_if_rdata;
    assign bus.mem_rdata  = r_mem_rdata;
    assign bus.stall      = (bus.mem_req & ~w_mem_ack) | (bus.if_req & ~w_if_ack);

    assign w_unused_bits = ^{bus.if_addr[1:0], bus.if_addr[31:ADDR_W+2], bus.mem_addr[31:ADDR_W+2]};

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: default build (WAIT_CYCLES=2) plus a WAIT_CYCLES=1 build.
module tb_sram_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sram_arbiter_if #(.ADDR_W(20)) bus  ();
    sram_arbiter_if #(.ADDR_W(20)) bus1 ();

    sram_arbiter #(.ADDR_W(20), .WAIT_CYCLES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    sram_arbiter #(.ADDR_W(20), .WAIT_CYCLES(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    logic [31:0] mem0 [0:127];
    logic [31:0] mem1 [0:127];
    logic        poke_en = 1'b0;
    logic [6:0]  poke_a  = 7'd0;
    logic [31:0] poke_d  = 32'd0;

    assign bus.sram_rdata  = mem0[bus.sram_addr[6:0]];
    assign bus1.sram_rdata = mem1[bus1.sram_addr[6:0]];

    always @(posedge clk) begin
        if (poke_en) begin
            mem0[poke_a] <= poke_d;
            mem1[poke_a] <= poke_d;
        end else begin
            if (!bus.sram_ce_n && !bus.sram_we_n)   mem0[bus.sram_addr[6:0]]  <= bus.sram_wdata;
            if (!bus1.sram_ce_n && !bus1.sram_we_n) mem1[bus1.sram_addr[6:0]] <= bus1.sram_wdata;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [6:0] a, input logic [31:0] d);
        poke_en = 1'b1;
        poke_a  = a;
        poke_d  = d;
        tick();
        poke_en = 1'b0;
    endtask

    // Issues one data access from IDLE and returns the result and cycles-to-ack.
    task automatic mem_op(input logic we, input logic bt, input logic [31:0] a,
                          input logic [31:0] wd, output logic [31:0] rd, output int lat);
        bus.mem_req   = 1'b1;
        bus.mem_we    = we;
        bus.mem_byte  = bt;
        bus.mem_addr  = a;
        bus.mem_wdata = wd;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!bus.mem_ack && lat < 10);
        rd = bus.mem_rdata;
        bus.mem_req  = 1'b0;
        bus.mem_we   = 1'b0;
        bus.mem_byte = 1'b0;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        int          lat;
        logic [31:0] lb_exp [0:3];
        lb_exp[0] = 32'h0000_0001;
        lb_exp[1] = 32'h0000_007F;
        lb_exp[2] = 32'hFFFF_FFFF;
        lb_exp[3] = 32'hFFFF_FF80;

        bus.if_req = 1'b0;  bus.if_addr = 32'd0;
        bus.mem_req = 1'b0; bus.mem_we = 1'b0; bus.mem_byte = 1'b0;
        bus.mem_addr = 32'd0; bus.mem_wdata = 32'd0;
        bus1.if_req = 1'b0; bus1.if_addr = 32'd0;
        bus1.mem_req = 1'b0; bus1.mem_we = 1'b0; bus1.mem_byte = 1'b0;
        bus1.mem_addr = 32'd0; bus1.mem_wdata = 32'd0;
        rst = 1'b0;
        #2 rst = 1'b1;

        poke(7'd4,  32'h2108_0001);
        poke(7'd8,  32'hCAFE_0008);
        poke(7'd16, 32'h80FF_7F01);
        poke(7'd64, 32'hDEAD_BEEF);

        check("rst if_ack",     32'(bus.if_ack),    32'd0);
        check("rst mem_ack",    32'(bus.mem_ack),   32'd0);
        check("rst if_rdata",   bus.if_rdata,       32'd0);
        check("rst mem_rdata",  bus.mem_rdata,      32'd0);
        check("rst ce_n",       32'(bus.sram_ce_n), 32'd1);
        check("rst oe_n",       32'(bus.sram_oe_n), 32'd1);
        check("rst we_n",       32'(bus.sram_we_n), 32'd1);
        check("rst sram_addr",  32'(bus.sram_addr), 32'd0);
        check("rst sram_wdata", bus.sram_wdata,     32'd0);
        rst = 1'b0;
        tick();

        // Fetch only
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0010;
        #1 check("f stall t", 32'(bus.stall), 32'd1);
        tick();
        check("f addr",      32'(bus.sram_addr), 32'd4);
        check("f oe_n 1",    32'(bus.sram_oe_n), 32'd0);
        check("f ce_n 1",    32'(bus.sram_ce_n), 32'd0);
        check("f we_n 1",    32'(bus.sram_we_n), 32'd1);
        check("f ack t+1",   32'(bus.if_ack),    32'd0);
        check("f stall t+1", 32'(bus.stall),     32'd1);
        tick();
        check("f oe_n 2",    32'(bus.sram_oe_n), 32'd0);
        check("f ack t+2",   32'(bus.if_ack),    32'd0);
        check("f stall t+2", 32'(bus.stall),     32'd1);
        tick();
        check("f ack t+3",   32'(bus.if_ack),    32'd1);
        check("f rdata",     bus.if_rdata,       32'h2108_0001);
        check("f oe_n ack",  32'(bus.sram_oe_n), 32'd1);
        check("f stall t+3", 32'(bus.stall),     32'd0);
        bus.if_req = 1'b0;
        tick();
        check("f ack drop",  32'(bus.if_ack),    32'd0);
        check("f rdata hold", bus.if_rdata,      32'h2108_0001);

        // Simultaneous requests: DATA first, then INST
        bus.mem_req  = 1'b1;
        bus.mem_addr = 32'h0000_0100;
        bus.if_req   = 1'b1;
        bus.if_addr  = 32'h0000_0020;
        tick();
        check("both addr data", 32'(bus.sram_addr), 32'd64);
        tick();
        tick();
        check("both mem_ack",   32'(bus.mem_ack),   32'd1);
        check("both mem_rdata", bus.mem_rdata,      32'hDEAD_BEEF);
        check("both if_ack t3", 32'(bus.if_ack),    32'd0);
        check("both stall t3",  32'(bus.stall),     32'd1);
        bus.mem_req = 1'b0;
        tick();
        check("both idle ce_n", 32'(bus.sram_ce_n), 32'd1);
        check("both stall t4",  32'(bus.stall),     32'd1);
        tick();
        check("both addr inst", 32'(bus.sram_addr), 32'd8);
        tick();
        check("both if_ack t6", 32'(bus.if_ack),    32'd0);
        tick();
        check("both if_ack t7", 32'(bus.if_ack),    32'd1);
        check("both mem_ack t7", 32'(bus.mem_ack),  32'd0);
        check("both if_rdata",  bus.if_rdata,       32'hCAFE_0008);
        bus.if_req = 1'b0;
        tick();

        // Store word then read it back
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = 32'h0000_0008;
        bus.mem_wdata = 32'h1234_5678;
        tick();
        check("sw we_n 1",  32'(bus.sram_we_n), 32'd0);
        check("sw oe_n 1",  32'(bus.sram_oe_n), 32'd1);
        check("sw addr 1",  32'(bus.sram_addr), 32'd2);
        check("sw wdata",   bus.sram_wdata,     32'h1234_5678);
        tick();
        check("sw we_n 2",  32'(bus.sram_we_n), 32'd1);
        check("sw ce_n 2",  32'(bus.sram_ce_n), 32'd0);
        check("sw oe_n 2",  32'(bus.sram_oe_n), 32'd1);
        check("sw addr 2",  32'(bus.sram_addr), 32'd2);
        tick();
        check("sw mem_ack", 32'(bus.mem_ack),   32'd1);
        bus.mem_req = 1'b0;
        bus.mem_we  = 1'b0;
        tick();
        mem_op(1'b0, 1'b0, 32'h0000_0008, 32'd0, rd, lat);
        check("lw back data", rd,          32'h1234_5678);
        check("lw back lat",  32'(lat),    32'd3);

        // Byte loads, all four lanes
        for (int i = 0; i < 4; i++) begin
            mem_op(1'b0, 1'b1, 32'h0000_0040 + 32'(i), 32'd0, rd, lat);
            check($sformatf("lb lane%0d", i), rd, lb_exp[i]);
        end

        // Reset in the second ACCESS cycle of a fetch
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0010;
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("rr ce_n",  32'(bus.sram_ce_n), 32'd1);
        check("rr oe_n",  32'(bus.sram_oe_n), 32'd1);
        check("rr we_n",  32'(bus.sram_we_n), 32'd1);
        check("rr addr",  32'(bus.sram_addr), 32'd0);
        check("rr ack",   32'(bus.if_ack),    32'd0);
        tick();
        check("rr ack held",   32'(bus.if_ack), 32'd0);
        check("rr rdata zero", bus.if_rdata,    32'd0);
        rst = 1'b0;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!bus.if_ack && lat < 10);
        check("rr relat",  32'(lat),      32'd3);
        check("rr rdata",  bus.if_rdata,  32'h2108_0001);
        bus.if_req = 1'b0;
        tick();

        // WAIT_CYCLES=1 build: held fetch acks every third cycle
        bus1.if_req  = 1'b1;
        bus1.if_addr = 32'h0000_0010;
        for (int k = 1; k <= 12; k++) begin
            tick();
            check($sformatf("w1 if_ack c%0d", k), 32'(bus1.if_ack), (k % 3 == 2) ? 32'd1 : 32'd0);
            check($sformatf("w1 one ack c%0d", k), 32'(bus1.if_ack & bus1.mem_ack), 32'd0);
        end
        check("w1 if_rdata", bus1.if_rdata, 32'h2108_0001);
        bus1.if_req = 1'b0;
        tick();
        bus1.mem_req   = 1'b1;
        bus1.mem_we    = 1'b1;
        bus1.mem_addr  = 32'h0000_000C;
        bus1.mem_wdata = 32'hA5A5_0C0C;
        tick();
        check("w1 sw we_n", 32'(bus1.sram_we_n), 32'd0);
        check("w1 sw addr", 32'(bus1.sram_addr), 32'd3);
        tick();
        check("w1 sw ack",  32'(bus1.mem_ack),   32'd1);
        bus1.mem_req = 1'b0;
        bus1.mem_we  = 1'b0;
        tick();
        check("w1 sw mem",  mem1[3],             32'hA5A5_0C0C);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
